// File: rtl/vga_pixel_gen.sv
// rtl/vga_pixel_gen.sv - two-stage VGA pixel pipeline drawing a bouncing, flashing box
// Optional screen border outline is built when BORDER_EN is defined.
module vga_pixel_gen #(
  parameter int BOX_SIZE     = 32,
  parameter int STEP         = 2,
  parameter int FLASH_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       pause,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       frame_tick
);

  localparam int          FW     = $clog2(FLASH_FRAMES + 1);
  localparam logic [10:0] X_MAX  = 11'(640 - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(480 - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

  typedef enum logic {RUN, PAUSED} state_t;

  state_t          r_state, w_state_next;
  logic [9:0]      r_bx, r_by, w_bx_next, w_by_next;
  logic            r_dx_left, r_dy_up, w_dx_left_next, w_dy_up_next;
  logic            w_bounce_x, w_bounce_y, w_move;
  logic [FW-1:0]   r_flash_cnt, w_flash_next;
  logic            r_vs_prev, r_frame_tick;
  logic            r1_active, r1_in_box, r1_white, r1_hs, r1_vs;
  logic            r2_hs, r2_vs;
  logic [7:0]      r2_rgb;
  logic [10:0]     w_bx_sum, w_bx_diff, w_by_sum, w_by_diff;
  logic            w_active, w_in_box;
`ifdef BORDER_EN
  logic            r1_border, w_border;
`endif

  always_comb begin
    w_state_next = r_state;
    if (r_frame_tick) begin
      if (r_state == RUN && pause)        w_state_next = PAUSED;
      else if (r_state == PAUSED && !pause) w_state_next = RUN;
    end
  end

  // Only a tick that leaves the FSM in RUN moves the box, so the pausing tick itself holds.
  assign w_move = r_frame_tick && (w_state_next == RUN);

  assign w_bx_sum  = {1'b0, r_bx} + STEP_W;
  assign w_bx_diff = {1'b0, r_bx} - STEP_W;
  assign w_by_sum  = {1'b0, r_by} + STEP_W;
  assign w_by_diff = {1'b0, r_by} - STEP_W;

  always_comb begin
    w_bx_next      = r_bx;
    w_by_next      = r_by;
    w_dx_left_next = r_dx_left;
    w_dy_up_next   = r_dy_up;
    w_bounce_x     = 1'b0;
    w_bounce_y     = 1'b0;
    if (!r_dx_left) begin
      if (w_bx_sum >= X_MAX) begin
        w_bx_next = X_MAX[9:0]; w_dx_left_next = 1'b1; w_bounce_x = 1'b1;
      end else w_bx_next = w_bx_sum[9:0];
    end else begin
      if ({1'b0, r_bx} < STEP_W + 11'd1) begin
        w_bx_next = 10'd0; w_dx_left_next = 1'b0; w_bounce_x = 1'b1;
      end else w_bx_next = w_bx_diff[9:0];
    end
    if (!r_dy_up) begin
      if (w_by_sum >= Y_MAX) begin
        w_by_next = Y_MAX[9:0]; w_dy_up_next = 1'b1; w_bounce_y = 1'b1;
      end else w_by_next = w_by_sum[9:0];
    end else begin
      if ({1'b0, r_by} < STEP_W + 11'd1) begin
        w_by_next = 10'd0; w_dy_up_next = 1'b0; w_bounce_y = 1'b1;
      end else w_by_next = w_by_diff[9:0];
    end
    if (w_bounce_x || w_bounce_y)  w_flash_next = FW'(FLASH_FRAMES);
    else if (r_flash_cnt != '0)    w_flash_next = r_flash_cnt - 1'b1;
    else                           w_flash_next = r_flash_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_bx         <= '0;
      r_by         <= '0;
      r_dx_left    <= 1'b0;
      r_dy_up      <= 1'b0;
      r_flash_cnt  <= '0;
      r_vs_prev    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_vs_prev    <= vsync_in;
      r_frame_tick <= r_vs_prev && !vsync_in;
      if (w_move) begin
        r_bx        <= w_bx_next;
        r_by        <= w_by_next;
        r_dx_left   <= w_dx_left_next;
        r_dy_up     <= w_dy_up_next;
        r_flash_cnt <= w_flash_next;
      end
    end
  end

  assign w_active = (x_in < 10'd640) && (y_in < 10'd480);
  assign w_in_box = ({1'b0, x_in} >= {1'b0, r_bx}) && ({1'b0, x_in} < {1'b0, r_bx} + BOX_W) &&
                    ({1'b0, y_in} >= {1'b0, r_by}) && ({1'b0, y_in} < {1'b0, r_by} + BOX_W);
`ifdef BORDER_EN
  assign w_border = (x_in == 10'd0) || (x_in == 10'd639) || (y_in == 10'd0) || (y_in == 10'd479);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_active <= 1'b0;
      r1_in_box <= 1'b0;
      r1_white  <= 1'b0;
      r1_hs     <= 1'b1;
      r1_vs     <= 1'b1;
`ifdef BORDER_EN
      r1_border <= 1'b0;
`endif
      r2_hs     <= 1'b1;
      r2_vs     <= 1'b1;
      r2_rgb    <= 8'h00;
    end else begin
      r1_active <= w_active;
      r1_in_box <= w_in_box;
      r1_white  <= (r_flash_cnt != '0) && r_flash_cnt[0];
      r1_hs     <= hsync_in;
      r1_vs     <= vsync_in;
`ifdef BORDER_EN
      r1_border <= w_border;
`endif
      r2_hs     <= r1_hs;
      r2_vs     <= r1_vs;
      if (!r1_active)     r2_rgb <= 8'h00;
      else if (r1_in_box) r2_rgb <= r1_white ? 8'hFF : 8'hE0;
`ifdef BORDER_EN
      else if (r1_border) r2_rgb <= 8'hFF;
`endif
      else                r2_rgb <= 8'h01;
    end
  end

  assign hsync_out          = r2_hs;
  assign vsync_out          = r2_vs;
  assign {red, green, blue} = r2_rgb;
  assign frame_tick         = r_frame_tick;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// tb/tb_vga_pixel_gen.sv - directed self-checking bench for vga_pixel_gen
module tb_vga_pixel_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync_in, vsync_in, pause;
  logic [9:0] x_in, y_in;
  logic       hsync_out, vsync_out, frame_tick;
  logic [2:0] red, green;
  logic [1:0] blue;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  vga_pixel_gen dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_in(x_in), .y_in(y_in), .pause(pause),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && frame_tick) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic [7:0] exp);
    x_in = px; y_in = py;
    @(negedge clk); @(negedge clk);
    check(tag, {24'h0, red, green, blue}, {24'h0, exp});
  endtask

  task automatic frame();
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  int hs_low, hs_first, hs_bad;
  logic exp_hs;

  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; pause = 1'b0; x_in = '0; y_in = '0;
    #3;
    check("rst_rgb", {red, green, blue}, 8'h00);
    check("rst_hs", hsync_out, 1'b1);
    check("rst_vs", vsync_out, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("lat1_rgb", {red, green, blue}, 8'h00);
    @(negedge clk);
    check("lat2_rgb", {red, green, blue}, 8'hE0);

    probe("box_31_31", 10'd31, 10'd31, 8'hE0);
    probe("bg_32_0", 10'd32, 10'd0, 8'h01);
    probe("bg_0_32", 10'd0, 10'd32, 8'h01);
    probe("blank_700", 10'd700, 10'd100, 8'h00);
    probe("blank_y480", 10'd100, 10'd480, 8'h00);
`ifdef BORDER_EN
    probe("border_639", 10'd639, 10'd200, 8'hFF);
`else
    probe("border_639", 10'd639, 10'd200, 8'h01);
`endif

    hs_low = 0; hs_first = -1; hs_bad = 0;
    for (int i = 0; i < 106; i++) begin
      exp_hs = (i >= 2 && i < 98) ? 1'b0 : 1'b1;
      if (hsync_out !== exp_hs) hs_bad++;
      if (!hsync_out) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      hsync_in = (i < 96) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("hs_len", hs_low, 96);
    check("hs_first", hs_first, 2);
    check("hs_align", hs_bad, 0);

    tick_cnt = 0;
    for (int f = 0; f < 10; f++) frame();
    check("tick_cnt10", tick_cnt, 10);
    check("bx_10", dut.r_bx, 20);
    check("by_10", dut.r_by, 20);
    probe("box_20_20", 10'd20, 10'd20, 8'hE0);
    probe("bg_19_20", 10'd19, 10'd20, 8'h01);

    for (int f = 10; f < 304; f++) frame();
    check("bx_304", dut.r_bx, 608);
    check("dx_304", dut.r_dx_left, 1'b1);
    check("flash_304", dut.r_flash_cnt, 15);
    check("by_304", dut.r_by, 288);
    probe("flash_white", 10'd608, 10'd288, 8'hFF);
    frame();
    check("bx_305", dut.r_bx, 606);
    check("by_305", dut.r_by, 286);
    probe("flash_red", 10'd606, 10'd286, 8'hE0);

    pause = 1'b1;
    for (int f = 0; f < 4; f++) frame();
    check("bx_paused", dut.r_bx, 606);
    check("flash_paused", dut.r_flash_cnt, 14);
    pause = 1'b0;
    frame();
    check("bx_resume", dut.r_bx, 604);
    pause = 1'b1; @(negedge clk); @(negedge clk);
    pause = 1'b0;
    frame();
    check("bx_glitch", dut.r_bx, 602);

    hsync_in = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_bx", dut.r_bx, 0);
    check("mid_by", dut.r_by, 0);
    check("mid_dx", dut.r_dx_left, 1'b0);
    check("mid_flash", dut.r_flash_cnt, 0);
    check("mid_hs", hsync_out, 1'b1);
    check("mid_rgb", {red, green, blue}, 8'h00);
    @(negedge clk);
    rst = 1'b0; hsync_in = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_gen.md
VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 SHALL have parameter BOX_SIZE, default 32, side length of the moving box in pixels.
REQ-002 SHALL have parameter STEP, default 2, box displacement per frame per axis in pixels.
REQ-003 SHALL have parameter FLASH_FRAMES, default 15, number of frames the box flashes after a wall bounce.
REQ-004 clk  in  1  pixel clock (25 MHz); rst  in  1  asynchronous, active-high reset.
REQ-005 hsync_in  in  1  active-low hsync from the timing generator.
REQ-006 vsync_in  in  1  active-low vsync from the timing generator.
REQ-007 x_in  in  10  pixel column, unsigned, active when below 640; y_in  in  10  pixel row, unsigned, active when below 480.
REQ-008 pause  in  1  level; freezes box motion while high.
REQ-009 hsync_out  out  1  and  vsync_out  out  1  carry the syncs delayed to align with the colour outputs.
REQ-010 red  out  3,  green  out  3,  blue  out  2  carry the 8-bit pixel colour.
REQ-011 frame_tick  out  1  is a one-cycle pulse on each vsync_in falling edge.

Function
REQ-012 SHALL have a fixed latency of 2 clk from x_in/y_in/syncs to the colour and sync outputs: stage 1 registers inputs and computes flags, stage 2 registers the colour.
REQ-013 Active = (x_in < 640) && (y_in < 480); when not active, colour SHALL be 0.
REQ-014 Colour priority SHALL be box, then border (REQ-025), then background 000_000_01.
REQ-015 Inside box = bx <= x_in < bx+BOX_SIZE and by <= y_in < by+BOX_SIZE; comparisons SHALL use 11-bit widths so no overflow occurs.
REQ-016 Box colour SHALL be 111_000_00, or 111_111_11 while flash_cnt is nonzero and flash_cnt[0] is 1.
REQ-017 Edge detection SHALL register vsync_in and raise frame_tick for exactly 1 clk when prev=1 and cur=0.
REQ-018 Motion FSM states: RUN and PAUSED. RUN goes to PAUSED on a frame_tick with pause=1; PAUSED goes to RUN on a frame_tick with pause=0; a pause change between ticks has no effect.
REQ-019 In RUN, on each frame_tick, bx SHALL move by STEP in direction dx and by SHALL move by STEP in direction dy; in PAUSED, position and direction SHALL hold.
REQ-020 X bounce: if dx=right and bx+STEP >= 640-BOX_SIZE, then bx SHALL be set to 640-BOX_SIZE and dx to left. If dx=left and bx < STEP+1, then bx SHALL be set to 0 and dx to right. Y bounce SHALL apply the same rule with bound 480-BOX_SIZE.
REQ-021 Any bounce SHALL load flash_cnt with FLASH_FRAMES. A simultaneous X and Y bounce (corner) SHALL load it once. Otherwise flash_cnt SHALL decrement by 1 per frame_tick, saturating at 0; it SHALL freeze in PAUSED.
REQ-022 Position updates SHALL occur only at frame_tick, so no mid-frame tearing occurs.

Reset
REQ-023 On rst, the following SHALL apply immediately, including mid-frame:
- bx=0, by=0, dx=right, dy=down, state RUN, flash_cnt=0, frame_tick=0;
- red/green/blue=0, hsync_out=1, vsync_out=1;
- all pipeline registers cleared, with sync stages set to 1 and the vsync edge register set to 1.
REQ-024 The first colour after rst deasserts SHALL appear 2 clk after the first input sample.

Configuration
REQ-025 Macro BORDER_EN:
- When defined, pixels with x_in = 0 or 639, or y_in = 0 or 479, SHALL be 111_111_11 unless inside the box.
- When undefined, no border logic SHALL exist and those pixels SHALL follow the box or background rule.

Verification
REQ-026 Reset, then drive x_in=0, y_in=0 -> two clk later the colour is 111_000_00 (box at origin).
REQ-027 Drive x_in=700, y_in=100 -> two clk later red/green/blue = 0; hsync_in pulse low for 96 clk -> hsync_out low for 96 clk, delayed 2 clk.
REQ-028 Apply 10 vsync falling edges with pause=0 -> bx=20, by=20; 10 frame_tick pulses, each 1 clk wide.
REQ-029 Run 304 frames -> bx=608, dx=left, flash_cnt=15 (the Y bounce at 224 frames has already expired); at frame 305 -> bx=606.
REQ-030 pause=1 before tick N -> bx unchanged after ticks N..N+3; pause=0 -> motion resumes on the next tick.
REQ-031 With BORDER_EN defined, x_in=639, y_in=200 -> 111_111_11; undefined -> 000_000_01.
